// File: rtl/madgwick_mul_arbiter_if.sv
// ---------------------------------------------------------------------------
// madgwick_mul_arbiter_if
// Bundles the requester-side handshake and the response bus of the shared
// Madgwick multiply/accumulate unit.
//   req_valid/req_ready : per-requester term handshake (one grant per cycle)
//   req_a/req_b         : packed signed operands, requester i at [i*W +: W]
//   req_neg/clr/last    : subtract term / restart accumulator / emit result
//   rsp_valid/rsp_data  : one-hot result strobe and signed result
//   busy                : any term still in flight
// master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface madgwick_mul_arbiter_if #(
    parameter int N_REQ     = 4,
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 16,
    parameter int ACC_WIDTH = A_WIDTH + B_WIDTH + 2
);
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ-1:0]         req_ready;
    logic [N_REQ*A_WIDTH-1:0] req_a;
    logic [N_REQ*B_WIDTH-1:0] req_b;
    logic [N_REQ-1:0]         req_neg;
    logic [N_REQ-1:0]         req_clr;
    logic [N_REQ-1:0]         req_last;
    logic [N_REQ-1:0]         rsp_valid;
    logic [ACC_WIDTH-1:0]     rsp_data;
    logic                     busy;

    modport master (
        output req_valid, req_a, req_b, req_neg, req_clr, req_last,
        input  req_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_neg, req_clr, req_last,
        output req_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/madgwick_mul_arbiter.sv
// ---------------------------------------------------------------------------
// madgwick_mul_arbiter
// One pipelined signed multiplier plus per-requester accumulators shared by
// N_REQ Madgwick datapath requesters. Round-robin grant, one term per cycle,
// in-order completion, one-hot tagged responses.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : madgwick_mul_arbiter_if.slave (handshake, operands, response, busy)
// Result latency is MUL_LATENCY+1 cycles after the handshake of a last term.
// ---------------------------------------------------------------------------
module madgwick_mul_arbiter #(
    parameter int N_REQ       = 4,
    parameter int A_WIDTH     = 16,
    parameter int B_WIDTH     = 16,
    parameter int MUL_LATENCY = 2,
    parameter int ACC_WIDTH   = A_WIDTH + B_WIDTH + 2
) (
    input logic                    clk,
    input logic                    rst_n,
    madgwick_mul_arbiter_if.slave  bus
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PW = A_WIDTH + B_WIDTH;
    localparam int LS = MUL_LATENCY - 1;

    logic [IW-1:0]             ptr_r;
    logic                      gnt_any_s;
    logic [IW-1:0]             gnt_idx_s;
    logic [IW-1:0]             scan_idx_s;
    logic [N_REQ-1:0]          gnt_s;
    logic signed [A_WIDTH-1:0] a_sel_s;
    logic signed [B_WIDTH-1:0] b_sel_s;
    logic signed [PW-1:0]      prod_s;

    logic [MUL_LATENCY-1:0]    pipe_vld_r;
    logic [MUL_LATENCY-1:0]    pipe_neg_r;
    logic [MUL_LATENCY-1:0]    pipe_clr_r;
    logic [MUL_LATENCY-1:0]    pipe_last_r;
    logic [IW-1:0]             pipe_tag_r  [MUL_LATENCY];
    logic signed [PW-1:0]      pipe_prod_r [MUL_LATENCY];

    logic signed [ACC_WIDTH-1:0] acc_r [N_REQ];
    logic signed [ACC_WIDTH-1:0] term_s;
    logic signed [ACC_WIDTH-1:0] base_s;
    logic signed [ACC_WIDTH-1:0] sum_s;
    logic [N_REQ-1:0]            rsp_valid_r;
    logic signed [ACC_WIDTH-1:0] rsp_data_r;
    logic                        busy_r;

    // Round-robin scan: first valid requester starting at ptr, wrapping.
    always_comb begin
        gnt_any_s  = 1'b0;
        gnt_idx_s  = '0;
        scan_idx_s = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx_s = IW'((int'(ptr_r) + k) % N_REQ);
            if (!gnt_any_s && bus.req_valid[scan_idx_s]) begin
                gnt_any_s = 1'b1;
                gnt_idx_s = scan_idx_s;
            end else begin
                gnt_any_s = gnt_any_s;
            end
        end
    end

    // One-hot grant vector; zero when nobody is requesting.
    always_comb begin
        gnt_s = '0;
        if (gnt_any_s) begin
            gnt_s[gnt_idx_s] = 1'b1;
        end else begin
            gnt_s = '0;
        end
    end

    assign bus.req_ready = gnt_s;

    // Operand mux and full-precision signed product of the granted requester.
    always_comb begin
        a_sel_s = bus.req_a[gnt_idx_s*A_WIDTH +: A_WIDTH];
        b_sel_s = bus.req_b[gnt_idx_s*B_WIDTH +: B_WIDTH];
        prod_s  = PW'(a_sel_s) * PW'(b_sel_s);
    end

    // Arbitration pointer and multiplier pipeline; a grant is always a
    // handshake because grants only go to valid requesters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r       <= '0;
            pipe_vld_r  <= '0;
            pipe_neg_r  <= '0;
            pipe_clr_r  <= '0;
            pipe_last_r <= '0;
            for (int s = 0; s < MUL_LATENCY; s++) begin
                pipe_tag_r[s]  <= '0;
                pipe_prod_r[s] <= '0;
            end
        end else begin
            if (gnt_any_s) begin
                ptr_r <= IW'((int'(gnt_idx_s) + 1) % N_REQ);
            end else begin
                ptr_r <= ptr_r;
            end
            pipe_vld_r[0]  <= gnt_any_s;
            pipe_neg_r[0]  <= bus.req_neg[gnt_idx_s];
            pipe_clr_r[0]  <= bus.req_clr[gnt_idx_s];
            pipe_last_r[0] <= bus.req_last[gnt_idx_s];
            pipe_tag_r[0]  <= gnt_idx_s;
            pipe_prod_r[0] <= prod_s;
            for (int s = 1; s < MUL_LATENCY; s++) begin
                pipe_vld_r[s]  <= pipe_vld_r[s-1];
                pipe_neg_r[s]  <= pipe_neg_r[s-1];
                pipe_clr_r[s]  <= pipe_clr_r[s-1];
                pipe_last_r[s] <= pipe_last_r[s-1];
                pipe_tag_r[s]  <= pipe_tag_r[s-1];
                pipe_prod_r[s] <= pipe_prod_r[s-1];
            end
        end
    end

    // Accumulate-stage arithmetic on the term leaving the pipeline.
    always_comb begin
        term_s = ACC_WIDTH'(pipe_prod_r[LS]);
        if (pipe_neg_r[LS]) begin
            term_s = -term_s;
        end else begin
            term_s = term_s;
        end
        if (pipe_clr_r[LS]) begin
            base_s = '0;
        end else begin
            base_s = acc_r[pipe_tag_r[LS]];
        end
        sum_s = base_s + term_s;
    end

    // Accumulator update, registered response and busy. busy is registered
    // from the next-state valids: a new grant or any pipeline stage feeding
    // either the next stage or the accumulate stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < N_REQ; r++) begin
                acc_r[r] <= '0;
            end
            rsp_valid_r <= '0;
            rsp_data_r  <= '0;
            busy_r      <= 1'b0;
        end else begin
            busy_r <= gnt_any_s | (|pipe_vld_r);
            if (pipe_vld_r[LS]) begin
                acc_r[pipe_tag_r[LS]] <= sum_s;
                if (pipe_last_r[LS]) begin
                    rsp_valid_r <= N_REQ'(1) << pipe_tag_r[LS];
                    rsp_data_r  <= sum_s;
                end else begin
                    rsp_valid_r <= '0;
                    rsp_data_r  <= rsp_data_r;
                end
            end else begin
                rsp_valid_r <= '0;
                rsp_data_r  <= rsp_data_r;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.busy      = busy_r;

endmodule
